// File: rtl/checker_pkg.sv
// checker_pkg: shared constants and types for the checker stream arbiter.
//   - Record delimiter characters and the idle filler char driven to the checker.
//   - format_type encodings returned by cpu_checker.
//   - Arbiter FSM state type.
//   - is_start_char(): true for chars that may open a record.
package checker_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_IDLE   = 8'h00;

  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_REG  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    WAIT  = 2'd2,
    ABORT = 2'd3
  } state_t;

  function automatic logic is_start_char(input logic [7:0] c);
    return (c == CH_CARET) || (c == CH_DOLLAR);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   in  N      requesting sources
//   last  in  SRC_W  source served most recently; scan starts at last+1
//   gnt   out N      one-hot winner (all zero when no request)
//   found out 1      at least one request present
module rr_pick #(
  parameter int N     = 2,
  parameter int SRC_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic             found
);

  // Scan distances 1..N from last; the first requester hit wins. Comparing
  // each constant position against the rotated index keeps every select static.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(last) + k) % N) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/checker_stream_arbiter.sv
// checker_stream_arbiter: shares one cpu_checker between N char-stream sources.
// A source wins the checker on a start char ('^' or '$') and keeps it until
// '#', a bubble, or MAX_LEN chars; the result is then returned tagged with the
// source id and arbitration resumes round-robin after the last served source.
//   clk, reset        clock; synchronous active-low reset
//   in_valid/in_char  per-source head char (char i at bits [8i+7:8i])
//   in_ready          per-source consume strobe (transfer = valid & ready)
//   chk_char          registered char stream into the checker (00 when idle)
//   chk_format_type   checker verdict, sampled RES_LAT cycles after '#'
//   grant, busy       one-hot owner of the checker; FSM not idle
//   res_*             one-cycle result pulse: source, format, abort flag
module checker_stream_arbiter
  import checker_pkg::*;
#(
  parameter int N       = 2,
  parameter int SRC_W   = 1,
  parameter int MAX_LEN = 64,
  parameter int RES_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     in_valid,
  input  logic [8*N-1:0]   in_char,
  output logic [N-1:0]     in_ready,
  output logic [7:0]       chk_char,
  input  logic [1:0]       chk_format_type,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic             res_valid,
  output logic [SRC_W-1:0] res_src,
  output logic [1:0]       res_format,
  output logic             res_abort
);

  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  localparam int WCNT_W = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

  state_t             state_q, state_d;
  logic [7:0]         chk_char_q, chk_char_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [SRC_W-1:0]   last_q, last_d;
  logic               res_valid_q, res_valid_d;
  logic [SRC_W-1:0]   res_src_q, res_src_d;
  logic [1:0]         res_format_q, res_format_d;
  logic               res_abort_q, res_abort_d;

  logic [7:0]         char_arr [N];
  logic [N-1:0]       cand;
  logic [N-1:0]       pick_gnt;
  logic               pick_found;
  logic [SRC_W-1:0]   win_idx;
  logic [7:0]         win_char;
  logic [7:0]         g_char;
  logic               g_valid;
  logic [N-1:0]       in_ready_c;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_src
      assign char_arr[gi] = in_char[8*gi +: 8];
      assign cand[gi]     = in_valid[gi] && is_start_char(char_arr[gi]);
    end
  endgenerate

  rr_pick #(.N(N), .SRC_W(SRC_W)) u_pick (
    .req   (cand),
    .last  (last_q),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  // One-hot to index/char for the arbitration winner and the current owner.
  always_comb begin
    win_idx  = '0;
    win_char = CH_IDLE;
    g_char   = CH_IDLE;
    for (int i = 0; i < N; i++) begin
      if (pick_gnt[i]) begin
        win_idx  = SRC_W'(i);
        win_char = char_arr[i];
      end
      if (grant_q[i]) g_char = g_char | char_arr[i];
    end
  end

  assign g_valid = |(in_valid & grant_q);

  always_comb begin
    state_d      = state_q;
    chk_char_d   = CH_IDLE;
    grant_d      = grant_q;
    src_d        = src_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    last_d       = last_q;
    res_valid_d  = 1'b0;
    res_src_d    = '0;
    res_format_d = FMT_NONE;
    res_abort_d  = 1'b0;
    in_ready_c   = '0;
    case (state_q)
      IDLE: begin
        // Non-start chars are junk and drained immediately; losing
        // candidates are held so their record is not disturbed.
        in_ready_c = in_valid & ~cand;
        if (pick_found) begin
          in_ready_c = in_ready_c | pick_gnt;
          chk_char_d = win_char;
          grant_d    = pick_gnt;
          src_d      = win_idx;
          cnt_d      = CNT_W'(1);
          state_d    = FWD;
        end
      end
      FWD: begin
        if (g_valid) begin
          in_ready_c = grant_q;
          chk_char_d = g_char;
          cnt_d      = cnt_q + CNT_W'(1);
          if (g_char == CH_HASH) begin
            state_d = WAIT;
            wcnt_d  = '0;
          end else if (cnt_q + CNT_W'(1) == CNT_W'(MAX_LEN)) begin
            state_d = ABORT;
          end
        end else begin
          // Bubble: the idle char reaching the checker breaks the record there too.
          state_d = ABORT;
        end
      end
      WAIT: begin
        if (wcnt_q == WCNT_W'(RES_LAT - 1)) begin
          res_valid_d  = 1'b1;
          res_src_d    = src_q;
          res_format_d = chk_format_type;
          last_d       = src_q;
          grant_d      = '0;
          state_d      = IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ABORT: begin
        res_valid_d = 1'b1;
        res_src_d   = src_q;
        res_abort_d = 1'b1;
        last_d      = src_q;
        grant_d     = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      chk_char_q   <= CH_IDLE;
      grant_q      <= '0;
      src_q        <= '0;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      last_q       <= SRC_W'(N - 1);
      res_valid_q  <= 1'b0;
      res_src_q    <= '0;
      res_format_q <= FMT_NONE;
      res_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      chk_char_q   <= chk_char_d;
      grant_q      <= grant_d;
      src_q        <= src_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      last_q       <= last_d;
      res_valid_q  <= res_valid_d;
      res_src_q    <= res_src_d;
      res_format_q <= res_format_d;
      res_abort_q  <= res_abort_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign chk_char   = chk_char_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign res_valid  = res_valid_q;
  assign res_src    = res_src_q;
  assign res_format = res_format_q;
  assign res_abort  = res_abort_q;

endmodule

// File: tb/tb_checker_stream_arbiter.sv
// Testbench for checker_stream_arbiter: directed scenarios followed by random
// records, checked each cycle against an ownership/deadline reference model.
module tb_checker_stream_arbiter;
  import checker_pkg::*;

  localparam int N       = 3;
  localparam int SRC_W   = 2;
  localparam int MAX_LEN = 40;
  localparam int RES_LAT = 2;
  localparam int BUF     = 4096;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     in_valid = '0;
  logic [8*N-1:0]   in_char = '0;
  logic [N-1:0]     in_ready;
  logic [7:0]       chk_char;
  logic [1:0]       chk_format_type = 2'd0;
  logic [N-1:0]     grant;
  logic             busy;
  logic             res_valid;
  logic [SRC_W-1:0] res_src;
  logic [1:0]       res_format;
  logic             res_abort;

  checker_stream_arbiter #(.N(N), .SRC_W(SRC_W), .MAX_LEN(MAX_LEN), .RES_LAT(RES_LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_char         (in_char),
    .in_ready        (in_ready),
    .chk_char        (chk_char),
    .chk_format_type (chk_format_type),
    .grant           (grant),
    .busy            (busy),
    .res_valid       (res_valid),
    .res_src         (res_src),
    .res_format      (res_format),
    .res_abort       (res_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-source pending chars.
  logic [7:0] sbuf [N][BUF];
  int shead [N];
  int stail [N];

  // Reference model: who owns the checker, how many chars it has sent, and the
  // edge number at which its result is due (-1 while still forwarding).
  int m_owner, m_len, m_due, m_abort, m_last;
  int k = 0;
  int hash_k = 0, last_lat = -1;
  int bub_src = -1, bub_len = 0, rand_bub = 0, fmt_fixed = 0;
  int nres = 0;
  int lg_src [1024];
  int lg_ab  [1024];
  int lg_fmt [1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_start(input logic [7:0] c);
    return (c == 8'h5E) || (c == 8'h24);
  endfunction

  function automatic logic all_empty();
    for (int i = 0; i < N; i++) if (shead[i] < stail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_byte(input int s, input logic [7:0] b);
    if (stail[s] < BUF) begin
      sbuf[s][stail[s]] = b;
      stail[s]++;
    end
  endtask

  task automatic push_str(input int s, input string str);
    for (int j = 0; j < str.len(); j++) push_byte(s, str[j]);
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin
      shead[i] = 0;
      stail[i] = 0;
    end
  endtask

  task automatic check_outputs(input logic [7:0] e_chk, input logic e_rv, input int e_rs,
                               input logic [1:0] e_rf, input logic e_ra);
    chk("chk_char", chk_char, e_chk);
    chk("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("busy", busy, (m_owner >= 0) ? 1 : 0);
    chk("res_valid", res_valid, e_rv);
    chk("res_src", res_src, e_rs);
    chk("res_format", res_format, e_rf);
    chk("res_abort", res_abort, e_ra);
  endtask

  task automatic observe();
    if (chk_char === 8'h23) hash_k = k;
    if (res_valid === 1'b1) begin
      if (nres < 1024) begin
        lg_src[nres] = int'(res_src);
        lg_ab[nres]  = int'(res_abort);
        lg_fmt[nres] = int'(res_format);
      end
      nres++;
      if (res_abort === 1'b0) last_lat = k - hash_k;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = '0;
    in_char  = '0;
    bub_src  = -1;
    @(posedge clk);
    #1;
    k++;
    m_owner = -1; m_len = 0; m_due = -1; m_abort = 0; m_last = N - 1;
    check_outputs(8'h00, 1'b0, 0, 2'd0, 1'b0);
    observe();
    reset = 1'b1;
  endtask

  task automatic step();
    logic [N-1:0] v, exp_rdy;
    logic [7:0]   c [N];
    logic [7:0]   e_chk;
    logic         e_rv, e_ra;
    logic [1:0]   e_rf, fmt;
    int           e_rs, win, kn, o;
    for (int i = 0; i < N; i++) begin
      logic bub;
      bub = (rand_bub != 0) && ($urandom_range(0, 15) == 0);
      if (bub_src == i && m_owner == i && m_due < 0 && m_len == bub_len) begin
        bub     = 1'b1;
        bub_src = -1;
      end
      v[i] = (shead[i] < stail[i]) && !bub;
      c[i] = v[i] ? sbuf[i][shead[i]] : 8'($urandom);
      in_valid[i]        = v[i];
      in_char[i*8 +: 8]  = c[i];
    end
    fmt = (fmt_fixed >= 0) ? 2'(fmt_fixed) : 2'($urandom_range(0, 3));
    chk_format_type = fmt;

    // Which sources the arbiter should consume this cycle.
    exp_rdy = '0;
    win     = -1;
    if (m_owner < 0) begin
      for (int d = 1; d <= N; d++) begin
        int i;
        i = (m_last + d) % N;
        if (win < 0 && v[i] && is_start(c[i])) win = i;
      end
      for (int i = 0; i < N; i++)
        if (v[i] && (!is_start(c[i]) || i == win)) exp_rdy[i] = 1'b1;
    end else if (m_due < 0) begin
      exp_rdy[m_owner] = v[m_owner];
    end
    #1;
    chk("in_ready", in_ready, exp_rdy);

    // Outputs expected right after the coming edge.
    kn = k + 1;
    e_chk = 8'h00; e_rv = 1'b0; e_rs = 0; e_rf = 2'd0; e_ra = 1'b0;
    if (m_owner < 0) begin
      if (win >= 0) begin
        e_chk   = c[win];
        m_owner = win;
        m_len   = 1;
      end
    end else if (m_due < 0) begin
      o = m_owner;
      if (v[o]) begin
        e_chk = c[o];
        m_len++;
        if (c[o] == 8'h23) begin
          m_due   = kn + RES_LAT;
          m_abort = 0;
        end else if (m_len == MAX_LEN) begin
          m_due   = kn + 1;
          m_abort = 1;
        end
      end else begin
        m_due   = kn + 1;
        m_abort = 1;
      end
    end else if (kn == m_due) begin
      e_rv    = 1'b1;
      e_rs    = m_owner;
      e_ra    = (m_abort != 0);
      e_rf    = (m_abort != 0) ? 2'd0 : fmt;
      m_last  = m_owner;
      m_owner = -1;
      m_due   = -1;
      m_abort = 0;
    end
    for (int i = 0; i < N; i++) if (exp_rdy[i]) shead[i]++;

    @(posedge clk);
    #1;
    k = kn;
    check_outputs(e_chk, e_rv, e_rs, e_rf, e_ra);
    observe();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((!all_empty() || m_owner >= 0) && n < bound) begin
      step();
      n++;
    end
    checks++;
    assert (n < bound) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d cycles, expected fewer than %0d", n, bound);
    end
  endtask

  task automatic push_random_record(input int s);
    int nj, nb;
    logic [7:0] b;
    nj = $urandom_range(0, 2);
    for (int j = 0; j < nj; j++) begin
      do b = 8'($urandom); while (is_start(b));
      push_byte(s, b);
    end
    push_byte(s, ($urandom_range(0, 1) == 0) ? 8'h5E : 8'h24);
    nb = $urandom_range(0, 45);
    for (int j = 0; j < nb; j++) begin
      do b = 8'($urandom_range(32, 126)); while (b == 8'h23);
      push_byte(s, b);
    end
    push_byte(s, 8'h23);
  endtask

  initial begin
    int base;
    string digits;
    for (int i = 0; i < 1024; i++) begin
      lg_src[i] = -1; lg_ab[i] = -1; lg_fmt[i] = -1;
    end
    clear_srcs();
    do_reset();
    do_reset();

    // 1: single record replayed one cycle late, result RES_LAT cycles after '#'.
    base = nres;
    fmt_fixed = int'(FMT_MEM);
    push_str(0, "^2422@000030f4: *31313131 <=12345678#");
    drain(200);
    chk("t1_nres", nres - base, 1);
    chk("t1_src", lg_src[base], 0);
    chk("t1_fmt", lg_fmt[base], 2);
    chk("t1_abort", lg_ab[base], 0);
    chk("t1_latency", last_lat, RES_LAT);

    // 2: simultaneous start after reset; source 0 first, no interleaving.
    do_reset();
    base = nres;
    fmt_fixed = int'(FMT_REG);
    push_str(0, "^2422@10:*1#");
    push_str(1, "$ab<=cd#");
    drain(200);
    chk("t2_nres", nres - base, 2);
    chk("t2_first", lg_src[base], 0);
    chk("t2_second", lg_src[base+1], 1);
    chk("t2_fmt", lg_fmt[base+1], 1);

    // 3: fairness with back-to-back records on source 0.
    do_reset();
    base = nres;
    fmt_fixed = -1;
    push_str(0, "^aa#^bb#");
    push_str(1, "^cc#^dd#");
    drain(300);
    chk("t3_nres", nres - base, 4);
    chk("t3_order0", lg_src[base], 0);
    chk("t3_order1", lg_src[base+1], 1);
    chk("t3_order2", lg_src[base+2], 0);
    chk("t3_order3", lg_src[base+3], 1);

    // 4: one-cycle bubble after 8 chars aborts; source 1 served next.
    base = nres;
    push_str(0, "^2422@000030f4#");
    push_str(1, "^9#");
    bub_src = 0;
    bub_len = 8;
    drain(300);
    chk("t4_nres", nres - base, 2);
    chk("t4_src", lg_src[base], 0);
    chk("t4_abort", lg_ab[base], 1);
    chk("t4_fmt", lg_fmt[base], 0);
    chk("t4_next_src", lg_src[base+1], 1);
    chk("t4_next_abort", lg_ab[base+1], 0);

    // 5: over-length record aborts, tail discarded; exactly MAX_LEN with '#' is fine.
    base = nres;
    digits = "";
    for (int j = 0; j < MAX_LEN + 1; j++) digits = {digits, "7"};
    push_str(2, {"^", digits});
    drain(300);
    chk("t5_nres", nres - base, 1);
    chk("t5_src", lg_src[base], 2);
    chk("t5_abort", lg_ab[base], 1);
    base = nres;
    digits = "";
    for (int j = 0; j < MAX_LEN - 2; j++) digits = {digits, "5"};
    push_str(1, {"^", digits, "#"});
    drain(300);
    chk("t5_edge_nres", nres - base, 1);
    chk("t5_edge_abort", lg_ab[base], 0);

    // 6a: junk ahead of a start char is drained without forwarding.
    base = nres;
    push_str(1, "ab^12#");
    drain(200);
    chk("t6_junk_nres", nres - base, 1);
    chk("t6_junk_src", lg_src[base], 1);
    chk("t6_junk_abort", lg_ab[base], 0);

    // 6b: reset mid-record drops it silently; source 0 has priority again.
    push_str(2, "^0123456789012345#");
    for (int j = 0; j < 6; j++) step();
    base = nres;
    clear_srcs();
    do_reset();
    for (int j = 0; j < 4; j++) step();
    chk("t6_rst_nres", nres - base, 0);
    push_str(1, "^x#");
    push_str(0, "^y#");
    drain(200);
    chk("t6_rst_after", nres - base, 2);
    chk("t6_rst_first", lg_src[base], 0);

    // Random records with random bubbles and checker verdicts.
    rand_bub = 1;
    fmt_fixed = -1;
    for (int r = 0; r < 10; r++) begin
      for (int s = 0; s < N; s++) begin
        int nrec;
        nrec = $urandom_range(0, 3);
        for (int j = 0; j < nrec; j++) push_random_record(s);
      end
      drain(20000);
    end
    rand_bub = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
